// File: rtl/mini68k_bus_pkg.sv
// rtl/mini68k_bus_pkg.sv - shared types, constants and decode helper for the 68000-style bus slave memory
package mini68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACC  = 3'd2,
        ACK  = 3'd3,
        IGN  = 3'd4
    } state_t;

    localparam logic [2:0] FC_IACK = 3'b111;

    // Window hit: every address bit above the RAM's byte span must match the base.
    function automatic logic win_hit(input logic [31:0] a, input logic [31:0] base, input int lsb);
        return (a >> lsb) == (base >> lsb);
    endfunction

endpackage

// File: rtl/mini68k_mem_sp_ram.sv
// rtl/mini68k_mem_sp_ram.sv - single-port 16-bit RAM with per-byte write enables and registered read
module mini68k_mem_sp_ram #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_wdata,
    input  logic [1:0]    i_be,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [0:(1<<AW)-1];

    // Byte-lane writes and a read-old-data registered read on the same address.
    always_ff @(posedge clk) begin
        if (i_be[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
        if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/mini68k_bus_mem.sv
// rtl/mini68k_bus_mem.sv - asynchronous-bus slave memory with wait states, bus error window and preload port
module mini68k_bus_mem
    import mini68k_bus_pkg::*;
#(
    parameter int                ADDR_W      = 24,
    parameter int                MEM_AW      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 2,
    parameter bit                IGNORE_IACK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              data_oe,
    input  logic              as_n,
    input  logic              rw,
    input  logic              uds_n,
    input  logic              lds_n,
    input  logic [2:0]        fc,
    output logic              dtack_n,
    output logic              berr_n,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic              ld_ready
);

    state_t            r_state, w_state_nx;
    logic [7:0]        r_cnt, w_cnt_nx;
    logic [MEM_AW-1:0] r_idx;
    logic              r_rw, r_uds_n, r_lds_n, r_hit;
    logic              r_dtack_n, w_dtack_n_nx;
    logic              r_berr_n, w_berr_n_nx;
    logic              r_data_oe, w_data_oe_nx;
    logic [15:0]       r_data_out, w_data_out_nx;
    logic              w_bus_wr;
    logic              w_ld_go;
    logic              w_start;
    logic [MEM_AW-1:0] w_ram_addr;
    logic [15:0]       w_ram_wdata, w_ram_rdata;
    logic [1:0]        w_ram_be;

    assign w_start  = (r_state == IDLE) && !as_n;
    assign ld_ready = (r_state == IDLE) && as_n;
    assign w_ld_go  = ld_we && ld_ready;

    // Preload owns the RAM only in IDLE with the bus quiet; otherwise the latched bus index drives it,
    // so the read issued during WAIT is ready by the time ACC hands it to the CPU.
    assign w_ram_addr  = w_ld_go ? ld_addr : r_idx;
    assign w_ram_wdata = w_ld_go ? ld_data : data_in;
    assign w_ram_be    = w_ld_go  ? 2'b11 :
                         w_bus_wr ? {~r_uds_n, ~r_lds_n} : 2'b00;

    // Next-state and next-output decode for the bus handshake.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_dtack_n_nx  = r_dtack_n;
        w_berr_n_nx   = r_berr_n;
        w_data_oe_nx  = r_data_oe;
        w_data_out_nx = r_data_out;
        w_bus_wr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!as_n) begin
                    if (IGNORE_IACK && (fc == FC_IACK)) begin
                        w_state_nx = IGN;
                    end else begin
                        w_state_nx = WAIT;
                        w_cnt_nx   = 8'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (as_n)               w_state_nx = IDLE;
                else if (r_cnt == 8'd0) w_state_nx = ACC;
                else                    w_cnt_nx   = r_cnt - 8'd1;
            end
            ACC: begin
                if (as_n) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = ACK;
                    if (r_hit && r_rw) begin
                        w_data_out_nx = w_ram_rdata;
                        w_data_oe_nx  = 1'b1;
                        w_dtack_n_nx  = 1'b0;
                    end else if (r_hit) begin
                        w_bus_wr     = 1'b1;
                        w_dtack_n_nx = 1'b0;
                    end else begin
                        w_berr_n_nx = 1'b0;
                    end
                end
            end
            ACK: begin
                if (as_n) begin
                    w_state_nx   = IDLE;
                    w_dtack_n_nx = 1'b1;
                    w_berr_n_nx  = 1'b1;
                    w_data_oe_nx = 1'b0;
                end
            end
            IGN: begin
                if (as_n) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State, wait counter and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_dtack_n  <= 1'b1;
            r_berr_n   <= 1'b1;
            r_data_oe  <= 1'b0;
            r_data_out <= 16'h0000;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_dtack_n  <= w_dtack_n_nx;
            r_berr_n   <= w_berr_n_nx;
            r_data_oe  <= w_data_oe_nx;
            r_data_out <= w_data_out_nx;
        end
    end

    // Capture the cycle's address decode and strobes when it is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_rw    <= 1'b1;
            r_uds_n <= 1'b1;
            r_lds_n <= 1'b1;
            r_hit   <= 1'b0;
        end else if (w_start) begin
            r_idx   <= addr[MEM_AW:1];
            r_rw    <= rw;
            r_uds_n <= uds_n;
            r_lds_n <= lds_n;
            r_hit   <= win_hit(32'(addr), 32'(BASE_ADDR), MEM_AW + 1);
        end
    end

    assign dtack_n  = r_dtack_n;
    assign berr_n   = r_berr_n;
    assign data_oe  = r_data_oe;
    assign data_out = r_data_out;

    mini68k_mem_sp_ram #(.AW(MEM_AW)) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_be    (w_ram_be),
        .o_rdata (w_ram_rdata)
    );

endmodule
